// File: rtl/h14tx_pkg.sv
// Shared HDMI 1.4 TMDS definitions used by both the TX encode and RX decode paths:
// period encoding, control/TERC4/guard code tables and the RX symbol classes.
package h14tx_pkg;

  localparam int NUM_LANES = 3;

  typedef enum logic [2:0] {
    PER_CONTROL,
    PER_VIDEO_PREAMBLE,
    PER_VIDEO_GUARD,
    PER_VIDEO_ACTIVE,
    PER_DI_PREAMBLE,
    PER_DI_GUARD,
    PER_DI_ACTIVE
  } period_t;

  // CLS_CTL must stay the zero encoding: a cleared lane record reads as a control symbol.
  typedef enum logic [2:0] {
    CLS_CTL,
    CLS_TERC4,
    CLS_VGUARD,
    CLS_DIGUARD,
    CLS_OTHER
  } h14rx_sym_class_e;

  typedef enum logic [2:0] {
    ST_CTRL,
    ST_VGUARD,
    ST_VIDEO,
    ST_DILEAD,
    ST_DIACT,
    ST_DITRAIL
  } h14rx_state_e;

  // Index = ctl pair {c1,c0}
  localparam logic [3:0][9:0] CTL_CODE = {10'h2AB, 10'h154, 10'h0AB, 10'h354};

  // Index = TERC4 nibble
  localparam logic [15:0][9:0] TERC4_CODE = {
    10'h2C3, 10'h163, 10'h271, 10'h28E, 10'h2C6, 10'h19C, 10'h139, 10'h2CC,
    10'h13C, 10'h18E, 10'h11E, 10'h171, 10'h2E2, 10'h2E4, 10'h263, 10'h29C
  };

  // Index = channel
  localparam logic [2:0][9:0] VIDEO_GUARD = {10'h2CC, 10'h133, 10'h2CC};
  localparam logic [9:0]      DATA_ISLAND_GUARD = 10'h133;

  typedef struct packed {
    h14rx_sym_class_e cls;
    logic             vguard;
    logic             t4_ok;
    logic [1:0]       ctl;
    logic [3:0]       nib;
    logic [7:0]       video;
  } h14rx_lane_t;

  function automatic logic [7:0] tmds_video_decode(input logic [9:0] q);
    logic [7:0] qm;
    logic [7:0] d;
    qm   = q[9] ? ~q[7:0] : q[7:0];
    d[0] = qm[0];
    for (int i = 1; i < 8; i++)
      d[i] = q[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
    return d;
  endfunction

endpackage

// File: rtl/h14rx_sym_classify.sv
// Per-lane combinational symbol classifier: code class plus every candidate decode
// (ctl pair, TERC4 nibble, video byte); the top picks which one is meaningful.
module h14rx_sym_classify
  import h14tx_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [9:0]  symbol,
  output h14rx_lane_t info
);

  logic       ctl_hit;
  logic       t4_hit;
  logic       vg_hit;
  logic [1:0] ctl_val;
  logic [3:0] nib_val;

  always_comb begin
    ctl_hit = 1'b0;
    ctl_val = '0;
    t4_hit  = 1'b0;
    nib_val = '0;
    for (int i = 0; i < 4; i++)
      if (symbol == CTL_CODE[i]) begin
        ctl_hit = 1'b1;
        ctl_val = 2'(i);
      end
    for (int i = 0; i < 16; i++)
      if (symbol == TERC4_CODE[i]) begin
        t4_hit  = 1'b1;
        nib_val = 4'(i);
      end
    vg_hit = (symbol == VIDEO_GUARD[LANE]);
  end

  // The video guard on ch0/ch2 is also TERC4 0x8, so TERC4 membership is a separate flag.
  always_comb begin
    info        = '0;
    info.vguard = vg_hit;
    info.t4_ok  = t4_hit;
    info.ctl    = ctl_val;
    info.nib    = nib_val;
    info.video  = tmds_video_decode(symbol);
    if (ctl_hit)
      info.cls = CLS_CTL;
    else if (LANE != 0 && symbol == DATA_ISLAND_GUARD)
      info.cls = CLS_DIGUARD;
    else if (vg_hit)
      info.cls = CLS_VGUARD;
    else if (t4_hit)
      info.cls = CLS_TERC4;
    else
      info.cls = CLS_OTHER;
  end

endmodule

// File: rtl/h14rx_period_decoder.sv
// HDMI 1.4 RX period decoder: classifies 3 aligned TMDS lanes, tracks preamble/guard/
// active framing and emits period, syncs and decoded payload with a fixed 2-clk latency.
module h14rx_period_decoder
  import h14tx_pkg::*;
#(
  parameter int PreambleLen = 8,
  parameter int GuardLen    = 2,
  parameter int PacketLen   = 32,
  parameter int MaxPackets  = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_LANES-1:0][9:0] symbol,
  output period_t                   period,
  output logic                      hsync,
  output logic                      vsync,
  output logic [NUM_LANES-1:0][1:0] ctl,
  output logic [NUM_LANES-1:0][3:0] data,
  output logic [NUM_LANES-1:0][7:0] video,
  output logic                      err
);

  if (MaxPackets * PacketLen > 1023 || PacketLen < 1 || MaxPackets < 1 ||
      PreambleLen < 1 || GuardLen < 1) begin : g_bad_params
    $error("h14rx_period_decoder: illegal parameter set");
  end

  localparam int PW = $clog2(PreambleLen + 1);
  localparam int GW = $clog2(GuardLen + 1);
  localparam logic [PW-1:0] PRE_SAT   = PW'(PreambleLen);
  localparam logic [GW-1:0] GUARD_END = GW'(GuardLen);
  localparam logic [9:0]    DI_MAX    = 10'(MaxPackets * PacketLen);
  localparam logic [9:0]    PKT       = 10'(PacketLen);

  // Stage 1: per-lane classification
  h14rx_lane_t [NUM_LANES-1:0] cls_c;
  h14rx_lane_t [NUM_LANES-1:0] s1;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    h14rx_sym_classify #(.LANE(i)) u_cls (
      .symbol (symbol[i]),
      .info   (cls_c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) s1 <= '0;
    else     s1 <= cls_c;
  end

  // Stage 2: framing FSM
  h14rx_state_e            state, state_n;
  logic [PW-1:0]           pre_cnt, pre_n;
  logic                    pre_kind, kind_n;   // 1 = data island preamble
  logic [GW-1:0]           g_cnt, g_n, g_inc;
  logic [9:0]              di_cnt, di_n;
  period_t                 per_n;
  logic                    err_n, hs_n, vs_n;
  logic [NUM_LANES-1:0][1:0] s1_ctl, ctl_n;
  logic [NUM_LANES-1:0][3:0] s1_nib, data_n;
  logic [NUM_LANES-1:0][7:0] s1_vid, video_n;
  logic all_ctl, all_t4, vg_all, di_guard, pre_vid, pre_di, pre_ok;

  always_comb begin
    all_ctl = 1'b1;
    all_t4  = 1'b1;
    vg_all  = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      all_ctl   &= (s1[i].cls == CLS_CTL);
      all_t4    &= s1[i].t4_ok;
      vg_all    &= s1[i].vguard;
      s1_ctl[i]  = s1[i].ctl;
      s1_nib[i]  = s1[i].nib;
      s1_vid[i]  = s1[i].video;
    end
    di_guard = (s1[1].cls == CLS_DIGUARD) && (s1[2].cls == CLS_DIGUARD) && s1[0].t4_ok;
    pre_vid  = all_ctl && s1[1].ctl == 2'b01 && s1[2].ctl == 2'b00;
    pre_di   = all_ctl && s1[1].ctl == 2'b01 && s1[2].ctl == 2'b01;
    pre_ok   = (pre_cnt >= PRE_SAT);
    g_inc    = g_cnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    kind_n  = pre_kind;
    g_n     = g_cnt;
    di_n    = di_cnt;
    per_n   = PER_CONTROL;
    err_n   = 1'b0;
    hs_n    = hsync;
    vs_n    = vsync;
    unique case (state)
      ST_CTRL: begin
        if (all_ctl) begin
          hs_n = s1[0].ctl[0];
          vs_n = s1[0].ctl[1];
          if (pre_vid || pre_di) begin
            per_n  = pre_di ? PER_DI_PREAMBLE : PER_VIDEO_PREAMBLE;
            kind_n = pre_di;
            if (pre_cnt == '0 || pre_kind != pre_di) pre_n = PW'(1);
            else if (!pre_ok)                          pre_n = pre_cnt + 1'b1;
          end else begin
            pre_n = '0;
          end
        end else if (vg_all && pre_ok && !pre_kind) begin
          per_n   = PER_VIDEO_GUARD;
          pre_n   = '0;
          g_n     = GW'(1);
          state_n = (GuardLen == 1) ? ST_VIDEO : ST_VGUARD;
        end else if (di_guard && pre_ok && pre_kind) begin
          per_n   = PER_DI_GUARD;
          pre_n   = '0;
          g_n     = GW'(1);
          di_n    = '0;
          hs_n    = s1[0].nib[0];
          vs_n    = s1[0].nib[1];
          state_n = (GuardLen == 1) ? ST_DIACT : ST_DILEAD;
        end else begin
          err_n = 1'b1;
          pre_n = '0;
        end
      end
      ST_VGUARD: begin
        if (vg_all) begin
          per_n = PER_VIDEO_GUARD;
          g_n   = g_inc;
          if (g_inc == GUARD_END) state_n = ST_VIDEO;
        end else begin
          err_n   = 1'b1;
          state_n = ST_CTRL;
        end
      end
      ST_VIDEO: begin
        if (all_ctl) begin
          state_n = ST_CTRL;
          hs_n    = s1[0].ctl[0];
          vs_n    = s1[0].ctl[1];
        end else begin
          per_n = PER_VIDEO_ACTIVE;
        end
      end
      ST_DILEAD: begin
        if (di_guard) begin
          per_n = PER_DI_GUARD;
          hs_n  = s1[0].nib[0];
          vs_n  = s1[0].nib[1];
          g_n   = g_inc;
          if (g_inc == GUARD_END) begin
            state_n = ST_DIACT;
            di_n    = '0;
          end
        end else begin
          err_n   = 1'b1;
          state_n = ST_CTRL;
        end
      end
      ST_DIACT: begin
        // A badly sized island still closes with its trailing guard, so only one err pulse.
        if (di_guard) begin
          per_n   = PER_DI_GUARD;
          hs_n    = s1[0].nib[0];
          vs_n    = s1[0].nib[1];
          err_n   = (di_cnt == '0) || ((di_cnt % PKT) != '0);
          g_n     = GW'(1);
          state_n = (GuardLen == 1) ? ST_CTRL : ST_DITRAIL;
        end else if (!all_t4 || di_cnt == DI_MAX) begin
          err_n   = 1'b1;
          state_n = ST_CTRL;
        end else begin
          per_n = PER_DI_ACTIVE;
          hs_n  = s1[0].nib[0];
          vs_n  = s1[0].nib[1];
          di_n  = di_cnt + 10'd1;
        end
      end
      ST_DITRAIL: begin
        if (di_guard) begin
          per_n = PER_DI_GUARD;
          hs_n  = s1[0].nib[0];
          vs_n  = s1[0].nib[1];
          g_n   = g_inc;
          if (g_inc == GUARD_END) state_n = ST_CTRL;
        end else begin
          err_n   = 1'b1;
          state_n = ST_CTRL;
        end
      end
      default: state_n = ST_CTRL;
    endcase
  end

  // Payload outputs are zero outside the periods in which they carry meaning
  always_comb begin
    ctl_n   = '0;
    data_n  = '0;
    video_n = '0;
    if (per_n == PER_CONTROL || per_n == PER_VIDEO_PREAMBLE || per_n == PER_DI_PREAMBLE)
      ctl_n = s1_ctl;
    if (per_n == PER_DI_ACTIVE)
      data_n = s1_nib;
    if (per_n == PER_VIDEO_ACTIVE)
      video_n = s1_vid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CTRL;
      pre_cnt  <= '0;
      pre_kind <= 1'b0;
      g_cnt    <= '0;
      di_cnt   <= '0;
      period   <= PER_CONTROL;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      ctl      <= '0;
      data     <= '0;
      video    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pre_cnt  <= pre_n;
      pre_kind <= kind_n;
      g_cnt    <= g_n;
      di_cnt   <= di_n;
      period   <= per_n;
      hsync    <= hs_n;
      vsync    <= vs_n;
      ctl      <= ctl_n;
      data     <= data_n;
      video    <= video_n;
      err      <= err_n;
    end
  end

endmodule
